adv_timer_seq: RTL and testbench

ADV_TIMER_SEQ -- requirements
Module: adv_timer_seq

---
 rtl/adv_timer_seq.sv | 165 ++++++++++++++++
 tb/tb_adv_timer_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/adv_timer_seq.sv
// Channel sequencer for an advanced timer: sequences start/stop/trigger gating,
// defers configuration updates to period ends and counts periods up to a repeat limit.
module adv_timer_seq #(
   parameter int unsigned REPEAT_W = 8
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                cmd_start_i,
   input  logic                cmd_stop_i,
   input  logic                cmd_update_i,
   input  logic                cmd_reset_i,
   input  logic [2:0]          cfg_trig_mode_i,
   input  logic                trig_i,
   input  logic [REPEAT_W-1:0] cfg_repeat_i,
   input  logic                timer_end_i,
   output logic                ctrl_active_o,
   output logic                ctrl_update_o,
   output logic                ctrl_rst_o,
   output logic [1:0]          state_o,
   output logic                done_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ARMED = 2'b01,
      RUN   = 2'b10
   } state_e;

   localparam logic [2:0] MODE_NONE = 3'd0;
   localparam logic [2:0] MODE_HIGH = 3'd1;
   localparam logic [2:0] MODE_LOW  = 3'd2;
   localparam logic [2:0] MODE_RISE = 3'd3;
   localparam logic [2:0] MODE_FALL = 3'd4;
   localparam logic [2:0] MODE_BOTH = 3'd5;

   state_e              state_q, state_d;
   logic [2:0]          mode_q, mode_d;
   logic [REPEAT_W-1:0] repeat_q, repeat_d;
   logic [REPEAT_W-1:0] cnt_q, cnt_d, cnt_base, cnt_inc;
   logic                trig_prev_q;
   logic                pending_q, pending_d, pending_base;
   logic                active_q, active_d;
   logic                update_q, update_d;
   logic                rst_q, rst_d;
   logic                done_q, done_d;
   logic                trig_ev, level_mode, level_inactive, start_none;

   always_comb begin
      trig_ev    = 1'b0;
      level_mode = 1'b0;
      case (mode_q)
         MODE_HIGH: begin trig_ev = trig_i;  level_mode = 1'b1; end
         MODE_LOW:  begin trig_ev = ~trig_i; level_mode = 1'b1; end
         MODE_RISE: trig_ev = trig_i & ~trig_prev_q;
         MODE_FALL: trig_ev = ~trig_i & trig_prev_q;
         MODE_BOTH: trig_ev = trig_i ^ trig_prev_q;
         default:   trig_ev = 1'b0;
      endcase
      level_inactive = level_mode & ~trig_ev;
   end

   // Reserved mode encodings behave exactly like "no trigger".
   assign start_none = (cfg_trig_mode_i == MODE_NONE) || (cfg_trig_mode_i > MODE_BOTH);

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      repeat_d = repeat_q;
      update_d = 1'b0;
      rst_d    = cmd_reset_i;
      done_d   = 1'b0;
      // A counter reset is folded in first so it composes with any other command.
      cnt_base     = cmd_reset_i ? '0 : cnt_q;
      pending_base = cmd_reset_i ? 1'b0 : pending_q;
      cnt_inc      = (&cnt_base) ? cnt_base : cnt_base + REPEAT_W'(1);
      cnt_d        = cnt_base;
      pending_d    = pending_base;

      if (cmd_update_i && (state_q != RUN)) begin
         update_d = 1'b1;
      end

      if (cmd_stop_i) begin
         state_d = IDLE;
         if (pending_base || cmd_update_i) begin
            update_d = 1'b1;
         end
         pending_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_start_i) begin
                  state_d  = start_none ? RUN : ARMED;
                  update_d = 1'b1;
                  rst_d    = 1'b1;
                  mode_d   = cfg_trig_mode_i;
                  repeat_d = cfg_repeat_i;
                  cnt_d    = '0;
               end
            end
            ARMED: begin
               if (trig_ev) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (cmd_update_i) begin
                  pending_d = 1'b1;
               end
               if (level_inactive) begin
                  state_d = ARMED;
               end
               // Period end: apply deferred update and check the repeat limit.
               if (timer_end_i) begin
                  cnt_d = cnt_inc;
                  if (pending_base || cmd_update_i) begin
                     update_d  = 1'b1;
                     pending_d = 1'b0;
                  end
                  if ((repeat_q != '0) && (cnt_inc == repeat_q)) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      active_d = (state_d == RUN);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= IDLE;
         mode_q      <= '0;
         repeat_q    <= '0;
         cnt_q       <= '0;
         trig_prev_q <= 1'b0;
         pending_q   <= 1'b0;
         active_q    <= 1'b0;
         update_q    <= 1'b0;
         rst_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         repeat_q    <= repeat_d;
         cnt_q       <= cnt_d;
         trig_prev_q <= trig_i;
         pending_q   <= pending_d;
         active_q    <= active_d;
         update_q    <= update_d;
         rst_q       <= rst_d;
         done_q      <= done_d;
      end
   end

   assign ctrl_active_o = active_q;
   assign ctrl_update_o = update_q;
   assign ctrl_rst_o    = rst_q;
   assign done_o        = done_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_adv_timer_seq.sv
// Directed bench for adv_timer_seq: the driver queues hand-computed expectations
// per cycle and a monitor compares them shortly after each rising edge.
module tb_adv_timer_seq;

   localparam logic [1:0] S_I = 2'b00;
   localparam logic [1:0] S_A = 2'b01;
   localparam logic [1:0] S_R = 2'b10;

   logic       clk = 1'b0;
   logic       rstn, start, stop, upd, rs, trig, te;
   logic [2:0] mode;
   logic [7:0] rep;
   logic       active_o, update_o, rst_o, done_o;
   logic [1:0] state_o;

   always #5 clk = ~clk;

   adv_timer_seq #(.REPEAT_W(8)) dut (
      .clk_i          (clk),
      .rstn_i         (rstn),
      .cmd_start_i    (start),
      .cmd_stop_i     (stop),
      .cmd_update_i   (upd),
      .cmd_reset_i    (rs),
      .cfg_trig_mode_i(mode),
      .trig_i         (trig),
      .cfg_repeat_i   (rep),
      .timer_end_i    (te),
      .ctrl_active_o  (active_o),
      .ctrl_update_o  (update_o),
      .ctrl_rst_o     (rst_o),
      .state_o        (state_o),
      .done_o         (done_o)
   );

   typedef struct packed {
      logic [1:0] st;
      logic       act;
      logic       upd;
      logic       rst;
      logic       done;
      logic       chk_cnt;
      logic [7:0] cnt;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_chk  = 0;
   int    n_pass = 0;

   task automatic clr_pulses();
      start = 1'b0; stop = 1'b0; upd = 1'b0; rs = 1'b0; te = 1'b0;
   endtask

   // Queue the outputs expected right after the next rising edge, then advance.
   task automatic tick(input string nm, input logic [1:0] st, input logic a, input logic u,
                       input logic r, input logic d, input logic cc = 1'b0,
                       input logic [7:0] c = 8'd0);
      exp_t e;
      e = '{st: st, act: a, upd: u, rst: r, done: d, chk_cnt: cc, cnt: c};
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
      clr_pulses();
   endtask

   task automatic run_te(input int n);
      repeat (n) begin
         te = 1'b1;
         @(negedge clk);
         te = 1'b0;
      end
   endtask

   task automatic chk_now(input string nm, input logic [5:0] got, input logic [5:0] want);
      n_chk++;
      if (got !== want)
         $display("FAIL %s: got st/act/upd/rst/done=%b required %b", nm, got, want);
      else
         n_pass++;
   endtask

   // Monitor: every cycle with a queued expectation is compared.
   always @(posedge clk) begin
      exp_t       e;
      string      nm;
      logic [5:0] got;
      #2;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         got = {state_o, active_o, update_o, rst_o, done_o};
         n_chk++;
         if (got !== {e.st, e.act, e.upd, e.rst, e.done})
            $display("FAIL %s: got st/act/upd/rst/done=%b required %b", nm, got,
                     {e.st, e.act, e.upd, e.rst, e.done});
         else
            n_pass++;
         if (e.chk_cnt) begin
            n_chk++;
            if (dut.cnt_q !== e.cnt)
               $display("FAIL %s_cnt: got count %0d required %0d", nm, dut.cnt_q, e.cnt);
            else
               n_pass++;
         end
      end
   end

   initial begin
      rstn = 1'b0; trig = 1'b0; mode = 3'd0; rep = 8'd0;
      clr_pulses();
      @(negedge clk);
      chk_now("reset_state", {state_o, active_o, update_o, rst_o, done_o}, 6'b000000);
      @(negedge clk);
      rstn = 1'b1;
      tick("after_reset", S_I, 0, 0, 0, 0, 1, 8'd0);

      // Mode none, repeat 3: runs three periods then stops with done.
      start = 1'b1; mode = 3'd0; rep = 8'd3;
      tick("a_start", S_R, 1, 1, 1, 0);
      te = 1'b1; tick("a_end1", S_R, 1, 0, 0, 0, 1, 8'd1);
      tick("a_gap", S_R, 1, 0, 0, 0, 1, 8'd1);
      te = 1'b1; tick("a_end2", S_R, 1, 0, 0, 0, 1, 8'd2);
      te = 1'b1; tick("a_end3", S_I, 0, 0, 0, 1);
      tick("a_done_once", S_I, 0, 0, 0, 0);

      // Rising-edge trigger.
      start = 1'b1; mode = 3'd3; rep = 8'd0; trig = 1'b0;
      tick("b_start", S_A, 0, 1, 1, 0);
      for (int i = 0; i < 10; i++) tick("b_armed_wait", S_A, 0, 0, 0, 0);
      trig = 1'b1; tick("b_rise", S_R, 1, 0, 0, 0);
      tick("b_high", S_R, 1, 0, 0, 0);
      trig = 1'b0; tick("b_fall_stays", S_R, 1, 0, 0, 0);
      stop = 1'b1; tick("b_stop", S_I, 0, 0, 0, 0);
      start = 1'b1; tick("b_rearm", S_A, 0, 1, 1, 0);
      trig = 1'b1; stop = 1'b1; tick("b_stop_prio", S_I, 0, 0, 0, 0);

      // Level-high gating.
      start = 1'b1; mode = 3'd1; trig = 1'b1;
      tick("c_start", S_A, 0, 1, 1, 0);
      tick("c_level_run", S_R, 1, 0, 0, 0);
      trig = 1'b0; tick("c_gate_off", S_A, 0, 0, 0, 0);
      tick("c_gated", S_A, 0, 0, 0, 0);
      trig = 1'b1; tick("c_gate_on", S_R, 1, 0, 0, 0);
      stop = 1'b1; tick("c_stop", S_I, 0, 0, 0, 0);

      // Deferred update to the period end.
      start = 1'b1; mode = 3'd0; rep = 8'd0; trig = 1'b0;
      tick("d_start", S_R, 1, 1, 1, 0);
      for (int i = 1; i < 20; i++) begin
         if (i == 5) upd = 1'b1;
         if (i == 10) start = 1'b1;
         tick("d_wait", S_R, 1, 0, 0, 0);
      end
      te = 1'b1; tick("d_apply", S_R, 1, 1, 0, 0);
      tick("d_apply_once", S_R, 1, 0, 0, 0);
      upd = 1'b1; stop = 1'b1; tick("d_upd_stop", S_I, 0, 1, 0, 0);
      tick("d_idle", S_I, 0, 0, 0, 0);
      upd = 1'b1; tick("d_upd_idle", S_I, 0, 1, 0, 0);

      // Free-running saturation and counter reset.
      start = 1'b1;
      tick("e_start", S_R, 1, 1, 1, 0, 1, 8'd0);
      upd = 1'b1; te = 1'b1; tick("e_coinc_upd", S_R, 1, 1, 0, 0, 1, 8'd1);
      run_te(298);
      te = 1'b1; tick("e_saturate", S_R, 1, 0, 0, 0, 1, 8'd255);
      rs = 1'b1; tick("e_cmd_reset", S_R, 1, 0, 1, 0, 1, 8'd0);
      tick("e_after_reset", S_R, 1, 0, 0, 0, 1, 8'd0);

      // Asynchronous reset in RUN with an update pending.
      upd = 1'b1; tick("f_pend", S_R, 1, 0, 0, 0);
      #2 rstn = 1'b0;
      #1 chk_now("f_async_drop", {state_o, active_o, update_o, rst_o, done_o}, 6'b000000);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      tick("f_release", S_I, 0, 0, 0, 0, 1, 8'd0);
      tick("f_no_pulse", S_I, 0, 0, 0, 0);
      start = 1'b1; tick("f_restart", S_R, 1, 1, 1, 0);
      te = 1'b1; tick("f_pend_gone", S_R, 1, 0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_chk++;
         $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
